// File: rtl/root_hub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : root_hub_pkg
// Description : Shared definitions for the root hub stage controller:
//               stage command codes broadcast to the children, the controller
//               state encoding and a state-to-stage-code helper.
// Revision    : 1.0 - initial release
// ============================================================================
package root_hub_pkg;

    localparam int STAGE_WIDTH = 3;

    typedef logic [STAGE_WIDTH-1:0] stage_t;

    localparam stage_t STAGE_IDLE                = 3'd0;
    localparam stage_t STAGE_MEASUREMENT_LOADING = 3'd1;
    localparam stage_t STAGE_GROW                = 3'd2;
    localparam stage_t STAGE_MERGE               = 3'd3;
    localparam stage_t STAGE_PEELING             = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEND_LOAD  = 3'd1,
        ST_SEND_GROW  = 3'd2,
        ST_SEND_MERGE = 3'd3,
        ST_SEND_PEEL  = 3'd4,
        ST_SETTLE     = 3'd5,
        ST_FINISH     = 3'd6
    } ctrl_state_e;

    // Stage code carried on the command bus while in a given state;
    // non-broadcast states present STAGE_IDLE.
    function automatic stage_t stage_of(input ctrl_state_e s);
        case (s)
            ST_SEND_LOAD:  return STAGE_MEASUREMENT_LOADING;
            ST_SEND_GROW:  return STAGE_GROW;
            ST_SEND_MERGE: return STAGE_MERGE;
            ST_SEND_PEEL:  return STAGE_PEELING;
            default:       return STAGE_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/root_hub_stage_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : root_hub_stage_controller_if
// Description : Downstream command channel and aggregated child status lines.
//               master = stage controller, slave = downstream children.
// Ports       : stage_cmd_data    stage code broadcast to all children
//               stage_cmd_valid   per-child command valid
//               stage_cmd_ready   per-child command ready
//               downstream_has_message_flying / downstream_has_odd_clusters
//                                 per-child status flags
// Revision    : 1.0 - initial release
// ============================================================================
interface root_hub_stage_controller_if #(
    parameter int NUM_CHILDREN = 2
);
    logic [root_hub_pkg::STAGE_WIDTH-1:0] stage_cmd_data;
    logic [NUM_CHILDREN-1:0]              stage_cmd_valid;
    logic [NUM_CHILDREN-1:0]              stage_cmd_ready;
    logic [NUM_CHILDREN-1:0]              downstream_has_message_flying;
    logic [NUM_CHILDREN-1:0]              downstream_has_odd_clusters;

    modport master (
        output stage_cmd_data,
        output stage_cmd_valid,
        input  stage_cmd_ready,
        input  downstream_has_message_flying,
        input  downstream_has_odd_clusters
    );

    modport slave (
        input  stage_cmd_data,
        input  stage_cmd_valid,
        output stage_cmd_ready,
        output downstream_has_message_flying,
        output downstream_has_odd_clusters
    );
endinterface
`default_nettype wire

// File: rtl/root_hub_stage_controller_broadcast_handshake.sv
`default_nettype none
// ============================================================================
// Module      : broadcast_handshake
// Description : Per-child valid/ready tracking for one command broadcast.
//               A child's valid drops the cycle after it accepts; the
//               broadcast completes once every child has accepted.
// Ports       : clk, reset        clock, synchronous active-high reset
//               active_i          a broadcast is in progress
//               ready_i[N]        per-child ready
//               valid_o[N]        per-child valid
//               complete_o        all children accepted (this cycle included)
// Revision    : 1.0 - initial release
// ============================================================================
module broadcast_handshake #(
    parameter int NUM_CHILDREN = 2
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    active_i,
    input  wire logic [NUM_CHILDREN-1:0] ready_i,
    output logic      [NUM_CHILDREN-1:0] valid_o,
    output logic                         complete_o
);
    logic [NUM_CHILDREN-1:0] done_mask_q;
    logic [NUM_CHILDREN-1:0] done_mask_d;
    logic [NUM_CHILDREN-1:0] accept;

    assign valid_o    = {NUM_CHILDREN{active_i}} & ~done_mask_q;
    assign accept     = valid_o & ready_i;
    // Include this cycle's accepts so an all-ready broadcast takes one cycle.
    assign complete_o = active_i && (&(done_mask_q | accept));

    always_comb begin
        done_mask_d = done_mask_q | accept;
        // Mask is cleared between broadcasts so the next one starts all-valid.
        if (!active_i || complete_o) begin
            done_mask_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_mask_q <= '0;
        end else begin
            done_mask_q <= done_mask_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/root_hub_stage_controller.sv
`default_nettype none
// ============================================================================
// Module      : root_hub_stage_controller
// Description : Sequences one decoding round of the root hub: load, repeated
//               grow/merge while odd clusters remain, then peel. Waits for the
//               network to stay quiet SETTLE_CYCLES cycles after each
//               load/merge/peel broadcast before deciding the next step.
// Ports       : clk, reset          clock, synchronous active-high reset
//               new_round_start     start request, honoured only when idle
//               bus (master)        command broadcast + child status lines
//               result_valid        round finished normally (level)
//               deadlock            round aborted (level)
//               iteration_counter   grow broadcasts completed this round
//               cycle_counter       cycles spent in this round (saturating)
// Option      : ROOT_HUB_WATCHDOG_EN - abort a round once cycle_counter
//               reaches WATCHDOG_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module root_hub_stage_controller
    import root_hub_pkg::*;
#(
    parameter int NUM_CHILDREN            = 2,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    parameter int MAX_ITERATIONS          = 255,
    parameter int SETTLE_CYCLES           = 4,
    parameter int WATCHDOG_CYCLES         = 65535
) (
    input  wire logic                               clk,
    input  wire logic                               reset,
    input  wire logic                               new_round_start,
    root_hub_stage_controller_if.master             bus,
    output logic                                    result_valid,
    output logic                                    deadlock,
    output logic [ITERATION_COUNTER_WIDTH-1:0]      iteration_counter,
    output logic [31:0]                             cycle_counter
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || WATCHDOG_CYCLES < 1 ||
        MAX_ITERATIONS >= (1 << ITERATION_COUNTER_WIDTH)) begin : g_param_check
        $error("root_hub_stage_controller: parameter out of range");
    end

    ctrl_state_e                        state_q, state_d;
    logic                               peel_q, peel_d;
    logic [3:0]                         settle_q, settle_d;
    logic                               result_valid_q, result_valid_d;
    logic                               deadlock_q, deadlock_d;
    logic [ITERATION_COUNTER_WIDTH-1:0] iter_q, iter_d;
    logic [31:0]                        cycle_q, cycle_d;

    logic send_active;
    logic bcast_done;
    logic watchdog_trip;
    logic any_flying;
    logic any_odd;

    assign any_flying = |bus.downstream_has_message_flying;
    assign any_odd    = |bus.downstream_has_odd_clusters;

`ifdef ROOT_HUB_WATCHDOG_EN
    assign watchdog_trip = (state_q != ST_IDLE) && (cycle_q >= 32'(WATCHDOG_CYCLES));
`else
    assign watchdog_trip = 1'b0;
`endif

    // A watchdog abort withdraws every valid in the same cycle.
    assign send_active = ((state_q == ST_SEND_LOAD) || (state_q == ST_SEND_GROW) ||
                          (state_q == ST_SEND_MERGE) || (state_q == ST_SEND_PEEL)) &&
                         !watchdog_trip;

    broadcast_handshake #(
        .NUM_CHILDREN (NUM_CHILDREN)
    ) u_broadcast_handshake (
        .clk        (clk),
        .reset      (reset),
        .active_i   (send_active),
        .ready_i    (bus.stage_cmd_ready),
        .valid_o    (bus.stage_cmd_valid),
        .complete_o (bcast_done)
    );

    assign bus.stage_cmd_data = stage_of(state_q);

    always_comb begin
        state_d        = state_q;
        peel_d         = peel_q;
        settle_d       = '0;
        result_valid_d = result_valid_q;
        deadlock_d     = deadlock_q;
        iter_d         = iter_q;
        cycle_d        = cycle_q;

        if (state_q != ST_IDLE && cycle_q != 32'hFFFF_FFFF) begin
            cycle_d = cycle_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (new_round_start) begin
                    result_valid_d = 1'b0;
                    deadlock_d     = 1'b0;
                    iter_d         = '0;
                    cycle_d        = '0;
                    peel_d         = 1'b0;
                    state_d        = ST_SEND_LOAD;
                end
            end
            ST_SEND_LOAD: begin
                if (bcast_done) state_d = ST_SETTLE;
            end
            ST_SEND_GROW: begin
                if (bcast_done) begin
                    iter_d  = iter_q + 1'b1;
                    state_d = ST_SEND_MERGE;
                end
            end
            ST_SEND_MERGE: begin
                if (bcast_done) state_d = ST_SETTLE;
            end
            ST_SEND_PEEL: begin
                if (bcast_done) begin
                    peel_d  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Any flying message restarts the quiet-period count.
                if (any_flying) begin
                    settle_d = '0;
                end else if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    if (peel_q) begin
                        state_d = ST_FINISH;
                    end else if (!any_odd) begin
                        state_d = ST_SEND_PEEL;
                    end else if (iter_q == ITERATION_COUNTER_WIDTH'(MAX_ITERATIONS)) begin
                        deadlock_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_SEND_GROW;
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_FINISH: begin
                result_valid_d = 1'b1;
                peel_d         = 1'b0;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (watchdog_trip) begin
            state_d        = ST_IDLE;
            deadlock_d     = 1'b1;
            result_valid_d = 1'b0;
            peel_d         = 1'b0;
            settle_d       = '0;
            iter_d         = iter_q;
            cycle_d        = cycle_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            peel_q         <= 1'b0;
            settle_q       <= '0;
            result_valid_q <= 1'b0;
            deadlock_q     <= 1'b0;
            iter_q         <= '0;
            cycle_q        <= '0;
        end else begin
            state_q        <= state_d;
            peel_q         <= peel_d;
            settle_q       <= settle_d;
            result_valid_q <= result_valid_d;
            deadlock_q     <= deadlock_d;
            iter_q         <= iter_d;
            cycle_q        <= cycle_d;
        end
    end

    assign result_valid      = result_valid_q;
    assign deadlock          = deadlock_q;
    assign iteration_counter = iter_q;
    assign cycle_counter     = cycle_q;
endmodule
`default_nettype wire

// File: tb/tb_root_hub_stage_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_root_hub_stage_controller
// Description : Self-checking bench for root_hub_stage_controller. Children
//               are emulated per cycle from a round plan (ready delays per
//               broadcast, flying windows per settle period); expected round
//               outcomes come from a table or from a round-level timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_root_hub_stage_controller;
    import root_hub_pkg::*;

    localparam int NCH    = 2;
    localparam int IW     = 8;
    localparam int MAXI   = 3;
    localparam int SETTLE = 4;
    localparam int WDOG   = 300;
    localparam int MAXRB  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           new_round_start;
    logic           result_valid;
    logic           deadlock;
    logic [IW-1:0]  iteration_counter;
    logic [31:0]    cycle_counter;

    root_hub_stage_controller_if #(.NUM_CHILDREN(NCH)) bus ();

    root_hub_stage_controller #(
        .NUM_CHILDREN            (NCH),
        .ITERATION_COUNTER_WIDTH (IW),
        .MAX_ITERATIONS          (MAXI),
        .SETTLE_CYCLES           (SETTLE),
        .WATCHDOG_CYCLES         (WDOG)
    ) dut (
        .clk               (clk),
        .reset             (rst),
        .new_round_start   (new_round_start),
        .bus               (bus),
        .result_valid      (result_valid),
        .deadlock          (deadlock),
        .iteration_counter (iteration_counter),
        .cycle_counter     (cycle_counter)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Round plan: ready delay per broadcast/child, flying window per settle.
    int dly  [MAXRB][NCH];
    int fat  [MAXRB];
    int flen [MAXRB];
    logic [NCH-1:0] vtrace [8];

    typedef struct {
        int k;        // grow iterations the children still want
        int d1;       // child1 ready delay for every broadcast
        int fa;       // flying start offset within each settle
        int fl;       // flying length within each settle
        bit exp_rv;
        int exp_iter;
        int exp_cc;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Round length from the protocol rules: each broadcast lasts until its
    // slowest child is ready, each settle needs SETTLE quiet cycles after the
    // last flying cycle, and a normal finish costs one extra cycle.
    function automatic int model_cc(input int k);
        int it, nb, ns, cc, m;
        bit ok;
        it = (k < MAXI) ? k : MAXI;
        ok = (k <= MAXI);
        nb = 1 + 2 * it + (ok ? 1 : 0);
        ns = 1 + it + (ok ? 1 : 0);
        cc = ok ? 1 : 0;
        for (int b = 0; b < nb; b++) begin
            m = 0;
            for (int c = 0; c < NCH; c++) if (dly[b][c] > m) m = dly[b][c];
            cc += m + 1;
        end
        for (int s = 0; s < ns; s++) cc += SETTLE + ((flen[s] > 0) ? fat[s] + flen[s] : 0);
        return cc;
    endfunction

    task automatic run_round(input int k, input bit noise, input bit exp_rv,
                             input int exp_iter, input int exp_cc, input string tag);
        int it, bidx, sidx, t, u, grows, cyc;
        bit settle_on, cmpl, seq_ok;
        logic [STAGE_WIDTH-1:0] prev_data, cur;
        logic [NCH-1:0] rdy;
        int seq[$];
        int exp_seq[$];

        it = (k < MAXI) ? k : MAXI;
        exp_seq.push_back(1);
        for (int i = 0; i < it; i++) begin
            exp_seq.push_back(2);
            exp_seq.push_back(3);
        end
        if (k <= MAXI) exp_seq.push_back(4);

        @(negedge clk) new_round_start = 1'b1;
        @(negedge clk) new_round_start = 1'b0;
        chk({tag, " start"},
            {bus.stage_cmd_data, bus.stage_cmd_valid, result_valid, deadlock, iteration_counter, cycle_counter},
            {3'd1, 2'b11, 1'b0, 1'b0, 8'd0, 32'd0});

        bidx = -1; sidx = 0; t = 0; u = 0; grows = 0; cyc = 0;
        settle_on = 1'b0; prev_data = '0;
        while (!(result_valid || deadlock) && cyc < 2000) begin
            cur = bus.stage_cmd_data;
            if (cyc < 8) vtrace[cyc] = bus.stage_cmd_valid;
            if (cur != 0 && cur != prev_data) begin
                bidx++;
                t = 0;
                seq.push_back(int'(cur));
                if (cur == STAGE_GROW) grows++;
                if (settle_on) begin
                    settle_on = 1'b0;
                    sidx++;
                end
            end else if (cur != 0) begin
                t++;
            end

            if (settle_on && sidx < MAXRB && u >= fat[sidx] && u < fat[sidx] + flen[sidx])
                bus.downstream_has_message_flying = 2'($urandom_range(1, 3));
            else
                bus.downstream_has_message_flying = '0;
            if (settle_on) u++;

            bus.downstream_has_odd_clusters = (grows < k) ? 2'($urandom_range(1, 3)) : 2'b00;

            rdy  = '0;
            cmpl = 1'b0;
            if (cur != 0 && bidx >= 0 && bidx < MAXRB) begin
                cmpl = 1'b1;
                for (int c = 0; c < NCH; c++) begin
                    if (bus.stage_cmd_valid[c]) begin
                        if (t >= dly[bidx][c]) rdy[c] = 1'b1;
                        else cmpl = 1'b0;
                    end else if (noise) begin
                        rdy[c] = 1'($urandom_range(0, 1));
                    end
                end
                if (cmpl && cur != STAGE_GROW) begin
                    settle_on = 1'b1;
                    u = 0;
                end
            end else if (noise) begin
                rdy = 2'($urandom_range(0, 3));
            end
            bus.stage_cmd_ready = rdy;
            new_round_start = noise && ($urandom_range(0, 7) == 0);
            prev_data = cur;
            cyc++;
            @(negedge clk);
        end
        new_round_start = 1'b0;
        bus.stage_cmd_ready = '0;
        bus.downstream_has_message_flying = '0;
        bus.downstream_has_odd_clusters = '0;

        if (cyc >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: no result_valid/deadlock within 2000 cycles", tag);
        end
        chk({tag, " result_valid"}, 64'(result_valid), 64'(exp_rv));
        chk({tag, " deadlock"}, 64'(deadlock), 64'(!exp_rv));
        chk({tag, " iteration_counter"}, 64'(iteration_counter), 64'(exp_iter));
        chk({tag, " cycle_counter"}, 64'(cycle_counter), 64'(exp_cc));
        chk({tag, " valid idle"}, 64'(bus.stage_cmd_valid), 64'(0));
        seq_ok = (seq.size() == exp_seq.size());
        for (int i = 0; i < seq.size() && i < exp_seq.size(); i++)
            if (seq[i] != exp_seq[i]) seq_ok = 1'b0;
        if (!seq_ok) $display("  %s: broadcast sequence got %p expected %p", tag, seq, exp_seq);
        chk({tag, " broadcast sequence"}, 64'(seq_ok), 64'(1));
        repeat (3) @(negedge clk);
        chk({tag, " hold in idle"}, {result_valid, deadlock, cycle_counter},
            {exp_rv, !exp_rv, 32'(exp_cc)});
    endtask

    initial begin
        int k;
        rst = 1'b1;
        new_round_start = 1'b0;
        bus.stage_cmd_ready = '0;
        bus.downstream_has_message_flying = '0;
        bus.downstream_has_odd_clusters = '0;

        //           k  d1 fa fl rv  iter cc
        vecs[0] = '{0, 0, 0, 0, 1'b1, 0, 11};  // load then quiet
        vecs[1] = '{2, 0, 0, 0, 1'b1, 2, 23};  // two grow iterations
        vecs[2] = '{0, 3, 0, 0, 1'b1, 0, 17};  // staggered ready
        vecs[3] = '{0, 0, 0, 1, 1'b1, 0, 13};  // flying at settle start
        vecs[4] = '{5, 0, 0, 0, 1'b0, 3, 23};  // iteration limit -> deadlock
        vecs[5] = '{3, 0, 0, 0, 1'b1, 3, 29};  // exactly MAX iterations
        vecs[6] = '{1, 2, 0, 2, 1'b1, 1, 31};  // delays and flying combined
        vecs[7] = '{0, 0, 3, 1, 1'b1, 0, 19};  // flying glitch at count 3

        repeat (3) @(negedge clk);
        chk("reset outputs",
            {bus.stage_cmd_data, bus.stage_cmd_valid, result_valid, deadlock, iteration_counter, cycle_counter},
            64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle after reset",
            {bus.stage_cmd_data, bus.stage_cmd_valid, result_valid, deadlock, iteration_counter, cycle_counter},
            64'(0));

        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < MAXRB; b++) begin
                dly[b][0] = 0;
                dly[b][1] = vecs[i].d1;
                fat[b]    = vecs[i].fa;
                flen[b]   = vecs[i].fl;
            end
            run_round(vecs[i].k, 1'b0, vecs[i].exp_rv, vecs[i].exp_iter, vecs[i].exp_cc,
                      $sformatf("vec%0d", i));
            if (vecs[i].d1 == 3) begin
                chk("stagger valid c0", 64'(vtrace[0]), 64'(2'b11));
                chk("stagger valid c1", 64'(vtrace[1]), 64'(2'b10));
                chk("stagger valid c3", 64'(vtrace[3]), 64'(2'b10));
                chk("stagger valid c4", 64'(vtrace[4]), 64'(2'b00));
            end
        end

        // Reset in the middle of a round: everything back to zero at once.
        bus.stage_cmd_ready = 2'b11;
        bus.downstream_has_odd_clusters = 2'b01;
        @(negedge clk) new_round_start = 1'b1;
        @(negedge clk) new_round_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid-round busy", {bus.stage_cmd_data, cycle_counter}, {3'd2, 32'd5});
        rst = 1'b1;
        @(negedge clk);
        chk("mid-round reset",
            {bus.stage_cmd_data, bus.stage_cmd_valid, result_valid, deadlock, iteration_counter, cycle_counter},
            64'(0));
        rst = 1'b0;
        bus.stage_cmd_ready = '0;
        bus.downstream_has_odd_clusters = '0;
        @(negedge clk);

        for (int r = 0; r < 30; r++) begin
            k = $urandom_range(0, 5);
            for (int b = 0; b < MAXRB; b++) begin
                for (int c = 0; c < NCH; c++) dly[b][c] = $urandom_range(0, 3);
                fat[b]  = $urandom_range(0, SETTLE - 1);
                flen[b] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            end
            run_round(k, 1'b1, (k <= MAXI), (k < MAXI) ? k : MAXI, model_cc(k),
                      $sformatf("rand%0d", r));
        end

`ifdef ROOT_HUB_WATCHDOG_EN
        begin
            int w;
            bus.stage_cmd_ready = 2'b01;
            @(negedge clk) new_round_start = 1'b1;
            @(negedge clk) new_round_start = 1'b0;
            w = 0;
            while (!deadlock && w < 1000) begin
                @(negedge clk);
                w++;
            end
            chk("watchdog abort",
                {bus.stage_cmd_valid, result_valid, deadlock, cycle_counter},
                {2'b00, 1'b0, 1'b1, 32'(WDOG)});
            bus.stage_cmd_ready = '0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
